// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared types and constants for the VGA display-mode path:
//             mode width, mode-sequencer state encoding and mode stepping.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Width of the display-mode bus seen by the mode consumer.
  localparam int unsigned MODE_W = 4;

  // Mode-sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Step to the next mode, wrapping to 0 after num_modes-1; any out-of-range
  // value also lands on 0 so an illegal code can never propagate.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m,
                                                  input int unsigned      num_modes);
    if (({{(32-MODE_W){1'b0}}, m} + 32'd1) >= num_modes) begin
      return '0;
    end
    return m + MODE_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Two-flop synchronizer plus level debouncer for a raw push-button.
//             Emits a one-cycle press pulse on the debounced 0->1 edge; a
//             release produces nothing.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rstn,
  input  logic key_raw,
  output logic press_pulse
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q,   lvl_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             press_q, press_d;

  // Next-state: shift the synchronizer, count consecutive disagreeing samples,
  // flip the level on the last one, and flag a rising level as a press.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule
`default_nettype wire

// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mode_ctrl
//  Purpose  : Display-mode sequencer. A debounced key press or an automatic
//             frame-count timeout arms a request; the request commits at the
//             next frame_start so the mode only changes during blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned NUM_MODES       = 11
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              key,
  input  logic              frame_start,
  input  logic              auto_en,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              pending
);

  localparam int unsigned      TMR_W    = $clog2(AUTO_FRAMES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_FRAMES - 1);

  logic              press;
  logic              auto_ev;
  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_changed_q, mode_changed_d;
  logic              pending_q, pending_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .sys_clk     (sys_clk),
    .sys_rstn    (sys_rstn),
    .key_raw     (key),
    .press_pulse (press)
  );

  // Frame timer: counts frames while enabled, fires on the last one, and is
  // cleared by any commit so the auto period restarts after a manual advance.
  always_comb begin
    auto_ev = auto_en & frame_start & (tmr_q == TMR_LAST);
    tmr_d   = tmr_q;
    if (!auto_en || (state_q == ST_COMMIT)) begin
      tmr_d = '0;
    end else if (frame_start) begin
      tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);
    end
  end

  // Sequencer next-state: events only register in IDLE, so extra requests
  // while armed or committing are dropped; the mode steps in COMMIT.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    mode_changed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press || auto_ev) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (frame_start) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d        = ST_IDLE;
        mode_d         = next_mode(mode_q, NUM_MODES);
        mode_changed_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pending_d = (state_d == ST_ARMED);
  end

  // Sequencer, timer and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q        <= ST_IDLE;
      mode_q         <= '0;
      mode_changed_q <= 1'b0;
      pending_q      <= 1'b0;
      tmr_q          <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      mode_changed_q <= mode_changed_d;
      pending_q      <= pending_d;
      tmr_q          <= tmr_d;
    end
  end

  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;
  assign pending      = pending_q;

endmodule
`default_nettype wire
